// File: rtl/game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : game_ctrl
// Brief    : Tic-tac-toe turn sequencer, move validator and win/draw detector
//            driving a single-cell write port into the board store.
// Revision : 1.0 - initial release
// ============================================================================
module game_ctrl #(
    parameter int N_CELLS = 9,
    parameter int CELL_W  = 2
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        new_game,
    input  logic                        x_valid,
    input  logic [3:0]                  x_cell,
    output logic                        x_ready,
    input  logic                        o_valid,
    input  logic [3:0]                  o_cell,
    output logic                        o_ready,
    input  logic [N_CELLS*CELL_W-1:0]   board,
    output logic                        clear,
    output logic                        wr_en,
    output logic [3:0]                  wr_cell,
    output logic [CELL_W-1:0]           wr_data,
    output logic [CELL_W-1:0]           turn,
    output logic                        game_over,
    output logic [CELL_W-1:0]           winner,
    output logic                        illegal
);

    typedef enum logic [2:0] {
        ST_CLEAR = 3'd0,
        ST_WAIT  = 3'd1,
        ST_WRITE = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [CELL_W-1:0] c_BLANK = CELL_W'(0);
    localparam logic [CELL_W-1:0] c_X     = CELL_W'(1);
    localparam logic [CELL_W-1:0] c_O     = CELL_W'(2);
    localparam logic [CELL_W-1:0] c_RSVD  = CELL_W'(3);
    localparam int                c_NLINE = 8;

    // Rows, then columns, then the two diagonals; three cell indices per line.
    localparam int c_LINE_CELLS [3*c_NLINE] = '{
        0, 1, 2,   3, 4, 5,   6, 7, 8,
        0, 3, 6,   1, 4, 7,   2, 5, 8,
        0, 4, 8,   2, 4, 6
    };

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CELL_W-1:0]    r_cur;
    logic [CELL_W-1:0]    w_cur_nxt;
    logic [3:0]           r_cnt;
    logic [3:0]           w_cnt_nxt;
    logic [3:0]           r_lat_cell;
    logic [3:0]           w_lat_cell_nxt;
    logic [CELL_W-1:0]    r_wr_data;
    logic [CELL_W-1:0]    w_wr_data_nxt;
    logic [CELL_W-1:0]    r_win;
    logic [CELL_W-1:0]    w_win_nxt;
    logic                 r_illegal;
    logic                 w_illegal_nxt;

    logic [CELL_W-1:0]    w_cell [N_CELLS];
    logic [c_NLINE-1:0]   w_line_win;
    logic                 w_req_valid;
    logic [3:0]           w_req_cell;
    logic [CELL_W-1:0]    w_target;
    logic                 w_legal;

    for (genvar gi = 0; gi < N_CELLS; gi++) begin : g_unpack
        assign w_cell[gi] = board[gi*CELL_W +: CELL_W];
    end

    for (genvar gl = 0; gl < c_NLINE; gl++) begin : g_line
        localparam int c_A = c_LINE_CELLS[3*gl];
        localparam int c_B = c_LINE_CELLS[3*gl+1];
        localparam int c_C = c_LINE_CELLS[3*gl+2];
        assign w_line_win[gl] = (w_cell[c_A] == r_cur) &&
                                (w_cell[c_B] == r_cur) &&
                                (w_cell[c_C] == r_cur);
    end

    assign w_req_valid = (r_cur == c_X) ? x_valid : o_valid;
    assign w_req_cell  = (r_cur == c_X) ? x_cell  : o_cell;

    // Out-of-range indices look up as RSVD so they fail the blank test.
    always_comb begin
        w_target = c_RSVD;
        for (int i = 0; i < N_CELLS; i++) begin
            if (w_req_cell == 4'(i)) begin
                w_target = w_cell[i];
            end
        end
    end

    assign w_legal = (w_target == c_BLANK);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_CLEAR;
            r_cur      <= c_X;
            r_cnt      <= 4'd0;
            r_lat_cell <= 4'd0;
            r_wr_data  <= c_BLANK;
            r_win      <= c_BLANK;
            r_illegal  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cur      <= w_cur_nxt;
            r_cnt      <= w_cnt_nxt;
            r_lat_cell <= w_lat_cell_nxt;
            r_wr_data  <= w_wr_data_nxt;
            r_win      <= w_win_nxt;
            r_illegal  <= w_illegal_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cur_nxt      = r_cur;
        w_cnt_nxt      = r_cnt;
        w_lat_cell_nxt = r_lat_cell;
        w_wr_data_nxt  = r_wr_data;
        w_win_nxt      = r_win;
        w_illegal_nxt  = 1'b0;

        clear     = (r_state == ST_CLEAR);
        x_ready   = (r_state == ST_WAIT) && (r_cur == c_X);
        o_ready   = (r_state == ST_WAIT) && (r_cur == c_O);
        wr_en     = (r_state == ST_WRITE);
        wr_cell   = r_lat_cell;
        wr_data   = r_wr_data;
        turn      = (r_state == ST_WAIT) ? r_cur : c_BLANK;
        game_over = (r_state == ST_DONE);
        winner    = (r_state == ST_DONE) ? r_win : c_BLANK;
        illegal   = r_illegal;

        case (r_state)
            ST_CLEAR: begin
                w_state_nxt = ST_WAIT;
                w_cur_nxt   = c_X;
                w_cnt_nxt   = 4'd0;
                w_win_nxt   = c_BLANK;
            end
            ST_WAIT: begin
                if (w_req_valid) begin
                    if (w_legal) begin
                        w_state_nxt    = ST_WRITE;
                        w_lat_cell_nxt = w_req_cell;
                        w_wr_data_nxt  = r_cur;
                    end else begin
                        w_illegal_nxt  = 1'b1;
                    end
                end
            end
            ST_WRITE: begin
                w_cnt_nxt   = r_cnt + 4'd1;
                w_state_nxt = ST_CHECK;
            end
            ST_CHECK: begin
                if (|w_line_win) begin
                    w_win_nxt   = r_cur;
                    w_state_nxt = ST_DONE;
                end else if (r_cnt == 4'(N_CELLS)) begin
                    w_win_nxt   = c_BLANK;
                    w_state_nxt = ST_DONE;
                end else begin
                    w_cur_nxt   = (r_cur == c_X) ? c_O : c_X;
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_DONE;
            end
            default: begin
                w_state_nxt = ST_CLEAR;
            end
        endcase

        // Restart wins over everything; a same-edge move leaves no trace.
        if (new_game) begin
            w_state_nxt    = ST_CLEAR;
            w_illegal_nxt  = 1'b0;
            w_lat_cell_nxt = r_lat_cell;
            w_wr_data_nxt  = r_wr_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_game_ctrl
// Brief    : Self-checking bench for game_ctrl with a board store and a
//            game-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_game_ctrl;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        new_game;
    logic        x_valid;
    logic [3:0]  x_cell;
    logic        x_ready;
    logic        o_valid;
    logic [3:0]  o_cell;
    logic        o_ready;
    logic [17:0] board_bus;
    logic        clear;
    logic        wr_en;
    logic [3:0]  wr_cell;
    logic [1:0]  wr_data;
    logic [1:0]  turn;
    logic        game_over;
    logic [1:0]  winner;
    logic        illegal;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;
    int wr_cnt = 0;

    logic       poke_en  = 1'b0;
    logic [3:0] poke_idx = 4'd0;

    always #5 clock = ~clock;

    game_ctrl #(.N_CELLS(9), .CELL_W(2)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .new_game  (new_game),
        .x_valid   (x_valid),
        .x_cell    (x_cell),
        .x_ready   (x_ready),
        .o_valid   (o_valid),
        .o_cell    (o_cell),
        .o_ready   (o_ready),
        .board     (board_bus),
        .clear     (clear),
        .wr_en     (wr_en),
        .wr_cell   (wr_cell),
        .wr_data   (wr_data),
        .turn      (turn),
        .game_over (game_over),
        .winner    (winner),
        .illegal   (illegal)
    );

    // Board store seen by the DUT; RSVD can be poked in to exercise that path.
    logic [1:0] st [9];
    always @(posedge clock) begin
        if (clear === 1'b1) begin
            for (int i = 0; i < 9; i++) st[i] <= 2'b00;
        end else begin
            if (wr_en === 1'b1 && wr_cell < 4'd9) st[wr_cell] <= wr_data;
            if (poke_en) st[poke_idx] <= 2'b11;
        end
    end

    always_comb begin
        board_bus = '0;
        for (int i = 0; i < 9; i++) board_bus[2*i +: 2] = st[i];
    end

    always @(posedge clock) if (wr_en === 1'b1) wr_cnt <= wr_cnt + 1;

    // Reference model: a game in progress, described by whose move it is,
    // the move count, and how far the last accepted move has progressed.
    logic [1:0] m_board [9];
    bit         m_clear  = 1'b1;
    bit         m_over   = 1'b0;
    bit         m_illegal = 1'b0;
    int         m_after  = 0;
    int         m_moves  = 0;
    logic [1:0] m_player = 2'b01;
    logic [1:0] m_win    = 2'b00;
    logic [3:0] m_cell   = 4'd0;

    logic       m_pv;
    logic [3:0] m_pc;
    assign m_pv = (m_player == 2'b01) ? x_valid : o_valid;
    assign m_pc = (m_player == 2'b01) ? x_cell  : o_cell;

    function automatic bit has_line(input logic [1:0] p);
        bit f = 1'b0;
        for (int r = 0; r < 3; r++) begin
            if (m_board[3*r] == p && m_board[3*r+1] == p && m_board[3*r+2] == p) f = 1'b1;
            if (m_board[r] == p && m_board[r+3] == p && m_board[r+6] == p) f = 1'b1;
        end
        if (m_board[0] == p && m_board[4] == p && m_board[8] == p) f = 1'b1;
        if (m_board[2] == p && m_board[4] == p && m_board[6] == p) f = 1'b1;
        return f;
    endfunction

    function automatic bit taken(input logic [3:0] c);
        if (c >= 4'd9) return 1'b1;
        return m_board[c] != 2'b00;
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_clear   <= 1'b1;
            m_after   <= 0;
            m_over    <= 1'b0;
            m_illegal <= 1'b0;
        end else begin
            m_illegal <= 1'b0;
            if (new_game) begin
                m_clear <= 1'b1;
                m_after <= 0;
                m_over  <= 1'b0;
            end else if (m_clear) begin
                m_clear  <= 1'b0;
                m_player <= 2'b01;
                m_moves  <= 0;
                m_win    <= 2'b00;
                for (int i = 0; i < 9; i++) m_board[i] <= 2'b00;
            end else if (m_after == 1) begin
                m_board[m_cell] <= m_player;
                m_moves <= m_moves + 1;
                m_after <= 2;
            end else if (m_after == 2) begin
                m_after <= 0;
                if (has_line(m_player)) begin
                    m_over <= 1'b1;
                    m_win  <= m_player;
                end else if (m_moves == 9) begin
                    m_over <= 1'b1;
                    m_win  <= 2'b00;
                end else begin
                    m_player <= (m_player == 2'b01) ? 2'b10 : 2'b01;
                end
            end else if (!m_over && m_pv) begin
                if (taken(m_pc)) m_illegal <= 1'b1;
                else begin
                    m_after <= 1;
                    m_cell  <= m_pc;
                end
            end
            if (!new_game && !m_clear && m_after == 0 && poke_en) m_board[poke_idx] <= 2'b11;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    logic       e_rdy;
    assign e_rdy = !m_clear && !m_over && (m_after == 0);

    always @(negedge clock) begin
        if (chk_en) begin
            chk("clear",     32'(clear),     32'(m_clear));
            chk("x_ready",   32'(x_ready),   32'(e_rdy && m_player == 2'b01));
            chk("o_ready",   32'(o_ready),   32'(e_rdy && m_player == 2'b10));
            chk("turn",      32'(turn),      32'(e_rdy ? m_player : 2'b00));
            chk("wr_en",     32'(wr_en),     32'(m_after == 1));
            if (m_after == 1) begin
                chk("wr_cell", 32'(wr_cell), 32'(m_cell));
                chk("wr_data", 32'(wr_data), 32'(m_player));
            end
            chk("game_over", 32'(game_over), 32'(m_over));
            chk("winner",    32'(winner),    32'(m_over ? m_win : 2'b00));
            chk("illegal",   32'(illegal),   32'(m_illegal));
        end
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clock); #1; end
    endtask

    task automatic play(input bit is_x, input logic [3:0] c);
        bit acc = 1'b0;
        if (is_x) begin x_valid = 1'b1; x_cell = c; end
        else      begin o_valid = 1'b1; o_cell = c; end
        for (int n = 0; n < 20 && !acc; n++) begin
            @(negedge clock);
            acc = is_x ? (x_ready === 1'b1) : (o_ready === 1'b1);
            @(posedge clock); #1;
        end
        if (is_x) x_valid = 1'b0; else o_valid = 1'b0;
        chk("play_accept", 32'(acc), 32'd1);
    endtask

    task automatic restart();
        new_game = 1'b1;
        idle(1);
        new_game = 1'b0;
    endtask

    initial begin
        int w0;
        reset_n = 1'b0; new_game = 1'b0;
        x_valid = 1'b0; x_cell = 4'd0; o_valid = 1'b0; o_cell = 4'd0;
        @(posedge clock); #1;
        chk_en = 1'b1;
        idle(2);
        chk("rst_clear",  32'(clear),   32'd1);
        chk("rst_xready", 32'(x_ready), 32'd0);
        reset_n = 1'b1; #1;
        chk("rel_clear",  32'(clear),   32'd1);
        @(posedge clock); #1;
        chk("init_xready", 32'(x_ready),   32'd1);
        chk("init_oready", 32'(o_ready),   32'd0);
        chk("init_turn",   32'(turn),      32'd1);
        chk("init_over",   32'(game_over), 32'd0);

        // X takes the top row
        w0 = wr_cnt;
        play(1, 0); play(0, 3); play(1, 1); play(0, 4); play(1, 2);
        idle(2);
        chk("xwin_over",   32'(game_over), 32'd1);
        chk("xwin_winner", 32'(winner),    32'd1);
        chk("xwin_xrdy",   32'(x_ready),   32'd0);
        chk("xwin_ordy",   32'(o_ready),   32'd0);
        chk("xwin_writes", 32'(wr_cnt - w0), 32'd5);

        // Full board with no line
        restart();
        w0 = wr_cnt;
        play(1, 0); play(0, 1); play(1, 2); play(0, 4); play(1, 3);
        play(0, 5); play(1, 7); play(0, 6); play(1, 8);
        idle(2);
        chk("draw_over",   32'(game_over), 32'd1);
        chk("draw_winner", 32'(winner),    32'd0);
        chk("draw_writes", 32'(wr_cnt - w0), 32'd9);

        // Occupied and out-of-range targets
        restart();
        play(1, 4); play(0, 4);
        chk("occ_illegal", 32'(illegal), 32'd1);
        chk("occ_wren",    32'(wr_en),   32'd0);
        chk("occ_turn",    32'(turn),    32'd2);
        play(0, 9);
        chk("oor_illegal", 32'(illegal), 32'd1);
        play(0, 8);
        chk("o8_wren",  32'(wr_en),   32'd1);
        chk("o8_cell",  32'(wr_cell), 32'd8);
        chk("o8_data",  32'(wr_data), 32'd2);

        // O requesting out of turn is ignored
        o_valid = 1'b1; o_cell = 4'd0;
        idle(3);
        chk("oot_ordy",    32'(o_ready), 32'd0);
        chk("oot_illegal", 32'(illegal), 32'd0);
        chk("oot_wren",    32'(wr_en),   32'd0);
        play(1, 0);
        o_valid = 1'b0;
        chk("x0_cell", 32'(wr_cell), 32'd0);
        chk("x0_data", 32'(wr_data), 32'd1);

        // Reserved cell contents are not blank
        idle(2);
        poke_en = 1'b1; poke_idx = 4'd2;
        idle(1);
        poke_en = 1'b0;
        play(0, 2);
        chk("rsvd_illegal", 32'(illegal), 32'd1);

        // Restart while a write is in flight
        play(0, 1);
        restart();
        chk("ngw_clear",  32'(clear),  32'd1);
        chk("ngw_wren",   32'(wr_en),  32'd0);
        chk("ngw_turn",   32'(turn),   32'd0);
        idle(1);
        chk("ngw_clear2", 32'(clear),     32'd0);
        chk("ngw_turn2",  32'(turn),      32'd1);
        chk("ngw_board",  32'(board_bus), 32'd0);

        // Restart from a finished game
        play(1, 0); play(0, 3); play(1, 1); play(0, 4); play(1, 2);
        idle(2);
        chk("ngd_over", 32'(game_over), 32'd1);
        restart();
        chk("ngd_clear",  32'(clear),     32'd1);
        chk("ngd_over2",  32'(game_over), 32'd0);
        chk("ngd_winner", 32'(winner),    32'd0);
        idle(1);
        chk("ngd_turn", 32'(turn), 32'd1);

        // Reset during the line check
        play(1, 0);
        idle(1);
        reset_n = 1'b0;
        idle(1);
        chk("rc_clear", 32'(clear), 32'd1);
        chk("rc_wren",  32'(wr_en), 32'd0);
        reset_n = 1'b1; #1;
        chk("rc_clear2", 32'(clear), 32'd1);
        @(posedge clock); #1;
        chk("rc_turn",   32'(turn),   32'd1);
        chk("rc_winner", 32'(winner), 32'd0);

        // Random play against the model
        for (int t = 0; t < 5000; t++) begin
            int r;
            r = int'($urandom_range(0, 999));
            new_game = (r < 12);
            reset_n  = (r < 996);
            x_valid  = 1'($urandom_range(0, 1));
            o_valid  = 1'($urandom_range(0, 1));
            x_cell   = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
            o_cell   = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
            poke_en  = 1'b0;
            if (r >= 12 && r < 30 && reset_n && !m_clear && m_after == 0) begin
                poke_en  = 1'b1;
                poke_idx = 4'($urandom_range(0, 8));
            end
            @(posedge clock); #1;
        end
        reset_n = 1'b1; poke_en = 1'b0;
        x_valid = 1'b0; o_valid = 1'b0; new_game = 1'b0;
        idle(2);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/game_ctrl.md
Name: game_ctrl

Overview:
Turn sequencer and move arbiter for the tic-tac-toe board store. It accepts move requests from two players (X and O) and grants only the player whose turn it is. Each accepted move is validated against the current board and then written through a single-cell write port. After each write it detects a win or draw and reports the game result. It sits between the player input front-ends and the board storage block.

Parameters:
N_CELLS, 9, number of board cells (3x3, row-major, cell = 3*row + col)
CELL_W, 2, bits per cell; encoding BLANK=2'b00, X=2'b01, O=2'b10, RSVD=2'b11

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
new_game  in  1  level; restart the game (clear board, X to move)
x_valid  in  1  player X move request
x_cell  in  4  X target cell index
x_ready  out  1  X move accepted when x_valid && x_ready
o_valid  in  1  player O move request
o_cell  in  4  O target cell index
o_ready  out  1  O move accepted when o_valid && o_ready
board  in  N_CELLS*CELL_W  current board state; cell i at bits [2i+1:2i]
clear  out  1  one-cycle pulse; board store blanks all cells
wr_en  out  1  one-cycle cell write strobe
wr_cell  out  4  cell index written when wr_en
wr_data  out  CELL_W  value written (X or O)
turn  out  CELL_W  player to move (X/O); BLANK outside WAIT
game_over  out  1  high in DONE
winner  out  CELL_W  X or O on a win; BLANK on a draw or while playing
illegal  out  1  one-cycle pulse; rejected move

Behaviour:
- FSM states: CLEAR, WAIT, WRITE, CHECK, DONE. Internal registers: state, cur (X/O), cnt (0..9), lat_cell (4b), win (2b).
- Async reset (reset_n=0): state=CLEAR, cur=X, cnt=0, win=BLANK, illegal=0. During and after reset: clear=1, all readys=0, wr_en=0, turn=BLANK, game_over=0, winner=BLANK.
- CLEAR: clear=1 for exactly one cycle. Next state is WAIT with cur=X, cnt=0, win=BLANK.
- WAIT: turn=cur. Only the current player's ready=1; the other player's ready=0 and its valid is ignored (no illegal pulse).
- Accept on the edge where the current player's valid&&ready=1. The controller latches the cell index.
- Move is illegal if cell > 8 or board[cell] != BLANK. On an illegal move: illegal=1 for the next cycle, state stays WAIT, cur is unchanged, and nothing is written.
- Move is legal otherwise. On a legal move, the next state is WRITE.
- WRITE: wr_en=1, wr_cell=lat_cell, wr_data=cur for one cycle. cnt increments by 1. Next state is CHECK.
- CHECK: the board now reflects the write (the store updates on the WRITE edge). The controller evaluates 8 lines: rows {0,1,2},{3,4,5},{6,7,8}; cols {0,3,6},{1,4,7},{2,5,8}; diags {0,4,8},{2,4,6}.
  - If any line has all three cells == cur: win=cur, go to DONE.
  - Else if cnt==9: win=BLANK, go to DONE (draw).
  - Else: cur toggles X<->O, go to WAIT.
- DONE: game_over=1, winner=win, readys=0. The controller holds until new_game.
- new_game=1 in any state forces CLEAR on the next edge. It takes priority over acceptance, WRITE and CHECK; a move handshaked on the same edge is discarded. Holding new_game high repeats CLEAR.
- Latency: accept edge k; wr_en in cycle k+1; CHECK in cycle k+2; next player's ready high in cycle k+3 (or game_over high in k+3).
- RSVD in the board input is treated as non-blank, so a move to that cell is illegal, and it never matches a line.
- wr_cell/wr_data hold their last values when wr_en=0; consumers must qualify them with wr_en.

Test Plan:
- Reset → clear=1 during reset and the first cycle after; then x_ready=1, o_ready=0, turn=X, game_over=0.
- X:0, O:3, X:1, O:4, X:2 → five wr_en pulses with wr_data alternating 01/10; 3 cycles after the last accept game_over=1, winner=X; both readys stay 0.
- X:0, O:1, X:2, O:4, X:3, O:5, X:7, O:6, X:8 → game_over=1, winner=BLANK (draw), cnt=9.
- X plays 4, then O requests 4 → illegal pulse one cycle, no wr_en, turn stays O. O then requests 9 → illegal again. O then requests 8 → accepted.
- o_valid=1 with o_cell=0 held during X's turn → o_ready=0, no illegal, no write. Then x_valid with x_cell=0 → accepted.
- new_game asserted in WRITE mid-game, then in DONE; reset_n pulsed low during CHECK → each returns to CLEAR, clear pulses once, turn=X, winner=BLANK, no stale wr_en.
